// File: rtl/l1d_port_arbiter.sv
// Two-requester arbiter in front of a single L1D issue port, with owner-tagged write-back routing.
// Optional build macro L1D_ARB_FIXED_PRIO_EN: requester A always wins ties instead of round-robin.
module l1d_port_arbiter #(
    parameter int MEM_LATENCY = 3
) (
    input  logic        clock_i,
    input  logic        reset_ni,
    input  logic        reqValidA_i,
    input  logic        reqValidB_i,
    output logic        reqReadyA_o,
    output logic        reqReadyB_o,
    input  logic [6:0]  opCodeA_i,
    input  logic [6:0]  opCodeB_i,
    input  logic        isWbA_i,
    input  logic        isWbB_i,
    input  logic [4:0]  wbAddressA_i,
    input  logic [4:0]  wbAddressB_i,
    input  logic [15:0] pOperandA_i,
    input  logic [15:0] sOperandA_i,
    input  logic [15:0] pOperandB_i,
    input  logic [15:0] sOperandB_i,
    input  logic        flush_i,
    output logic        flushDone_o,
    output logic        memValid_o,
    output logic [6:0]  memOpCode_o,
    output logic        memIsWb_o,
    output logic [4:0]  memWbAddress_o,
    output logic [15:0] memPOperand_o,
    output logic [15:0] memSOperand_o,
    input  logic        memWbEnable_i,
    input  logic [4:0]  memWbAddress_i,
    input  logic [15:0] memWbData_i,
    output logic        wbEnableA_o,
    output logic        wbEnableB_o,
    output logic [4:0]  wbAddressA_o,
    output logic [4:0]  wbAddressB_o,
    output logic [15:0] wbDataA_o,
    output logic [15:0] wbDataB_o
);

    localparam int CNT_W = $clog2(MEM_LATENCY + 1) + 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_reg;
    logic              flush_done_reg;
    logic              grant_a;
    logic              grant_b;
    logic              xfer;
    logic              issue_ok;
    logic [6:0]        sel_op;

    logic              mem_valid_reg;
    logic              mem_owner_reg;
    logic [6:0]        mem_op_reg;
    logic              mem_is_wb_reg;
    logic [4:0]        mem_wb_addr_reg;
    logic [15:0]       mem_p_op_reg;
    logic [15:0]       mem_s_op_reg;

    logic [MEM_LATENCY-1:0] tag_valid_reg;
    logic [MEM_LATENCY-1:0] tag_owner_reg;
    logic [MEM_LATENCY-1:0] tag_valid_next;
    logic [MEM_LATENCY-1:0] tag_owner_next;
    logic                   tag_last_valid;
    logic                   tag_last_owner;

    logic [CNT_W-1:0]  outstanding_reg;

    logic              wb_en_a_reg;
    logic              wb_en_b_reg;
    logic [4:0]        wb_addr_a_reg;
    logic [4:0]        wb_addr_b_reg;
    logic [15:0]       wb_data_a_reg;
    logic [15:0]       wb_data_b_reg;

`ifdef L1D_ARB_FIXED_PRIO_EN
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state_reg == ST_RUN && !flush_i) begin
            grant_a = reqValidA_i;
            grant_b = reqValidB_i && !reqValidA_i;
        end
    end
`else
    // 1 means B won the most recent transfer, so A takes the next tie.
    logic last_grant_reg;

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state_reg == ST_RUN && !flush_i) begin
            if (reqValidA_i && reqValidB_i) begin
                grant_a = last_grant_reg;
                grant_b = !last_grant_reg;
            end else begin
                grant_a = reqValidA_i;
                grant_b = reqValidB_i;
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            last_grant_reg <= 1'b1;
        end else if (grant_a || grant_b) begin
            last_grant_reg <= grant_b;
        end
    end
`endif

    assign xfer     = grant_a || grant_b;
    assign sel_op   = grant_b ? opCodeB_i : opCodeA_i;
    assign issue_ok = xfer && (sel_op == 7'd10 || sel_op == 7'd11 || sel_op == 7'd12);

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            mem_valid_reg   <= 1'b0;
            mem_owner_reg   <= 1'b0;
            mem_op_reg      <= '0;
            mem_is_wb_reg   <= 1'b0;
            mem_wb_addr_reg <= '0;
            mem_p_op_reg    <= '0;
            mem_s_op_reg    <= '0;
        end else begin
            mem_valid_reg <= issue_ok;
            if (issue_ok) begin
                mem_owner_reg   <= grant_b;
                mem_op_reg      <= sel_op;
                mem_is_wb_reg   <= grant_b ? isWbB_i      : isWbA_i;
                mem_wb_addr_reg <= grant_b ? wbAddressB_i : wbAddressA_i;
                mem_p_op_reg    <= grant_b ? pOperandB_i  : pOperandA_i;
                mem_s_op_reg    <= grant_b ? sOperandB_i  : sOperandA_i;
            end
        end
    end

    // Stage 0 captures the issue slot; the last stage lines up with the cache return.
    genvar gi;
    generate
        for (gi = 0; gi < MEM_LATENCY; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                assign tag_valid_next[gi] = mem_valid_reg;
                assign tag_owner_next[gi] = mem_owner_reg;
            end else begin : g_body
                assign tag_valid_next[gi] = tag_valid_reg[gi-1];
                assign tag_owner_next[gi] = tag_owner_reg[gi-1];
            end
        end
    endgenerate

    assign tag_last_valid = tag_valid_reg[MEM_LATENCY-1];
    assign tag_last_owner = tag_owner_reg[MEM_LATENCY-1];

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            tag_valid_reg <= '0;
            tag_owner_reg <= '0;
        end else begin
            tag_valid_reg <= tag_valid_next;
            tag_owner_reg <= tag_owner_next;
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            outstanding_reg <= '0;
        end else begin
            case ({mem_valid_reg, tag_last_valid})
                2'b10:   outstanding_reg <= outstanding_reg + CNT_W'(1);
                2'b01:   outstanding_reg <= outstanding_reg - CNT_W'(1);
                default: outstanding_reg <= outstanding_reg;
            endcase
        end
    end

    // Returns with no matching tag are dropped, which also discards anything issued before a reset.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wb_en_a_reg   <= 1'b0;
            wb_en_b_reg   <= 1'b0;
            wb_addr_a_reg <= '0;
            wb_addr_b_reg <= '0;
            wb_data_a_reg <= '0;
            wb_data_b_reg <= '0;
        end else begin
            wb_en_a_reg <= tag_last_valid && !tag_last_owner && memWbEnable_i;
            wb_en_b_reg <= tag_last_valid &&  tag_last_owner && memWbEnable_i;
            if (tag_last_valid && memWbEnable_i) begin
                if (tag_last_owner) begin
                    wb_addr_b_reg <= memWbAddress_i;
                    wb_data_b_reg <= memWbData_i;
                end else begin
                    wb_addr_a_reg <= memWbAddress_i;
                    wb_data_a_reg <= memWbData_i;
                end
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_reg      <= ST_RUN;
            flush_done_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (flush_i) begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (outstanding_reg == '0 && !mem_valid_reg) begin
                        state_reg      <= ST_DONE;
                        flush_done_reg <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!flush_i) begin
                        state_reg      <= ST_RUN;
                        flush_done_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg      <= ST_RUN;
                    flush_done_reg <= 1'b0;
                end
            endcase
        end
    end

    assign reqReadyA_o    = grant_a;
    assign reqReadyB_o    = grant_b;
    assign flushDone_o    = flush_done_reg;
    assign memValid_o     = mem_valid_reg;
    assign memOpCode_o    = mem_op_reg;
    assign memIsWb_o      = mem_is_wb_reg;
    assign memWbAddress_o = mem_wb_addr_reg;
    assign memPOperand_o  = mem_p_op_reg;
    assign memSOperand_o  = mem_s_op_reg;
    assign wbEnableA_o    = wb_en_a_reg;
    assign wbEnableB_o    = wb_en_b_reg;
    assign wbAddressA_o   = wb_addr_a_reg;
    assign wbAddressB_o   = wb_addr_b_reg;
    assign wbDataA_o      = wb_data_a_reg;
    assign wbDataB_o      = wb_data_b_reg;

endmodule

// File: doc/l1d_port_arbiter.md
L1D_PORT_ARBITER -- requirements
Module: l1d_port_arbiter

Interface
REQ-001 Parameter MEM_LATENCY, default 3: cycles from memValid_o high to the matching memWbEnable_i/memWbData_i sample at the cache.
REQ-002 clock_i  in  1  sole clock; all state changes on its rising edge.
REQ-003 reset_ni  in  1  reset, asynchronous, active-low.
REQ-004 reqValidA_i, reqValidB_i  in  1 each  requester A/B has an operation.
REQ-005 reqReadyA_o, reqReadyB_o  out  1 each  combinational grant; transfer occurs when valid and ready are both high.
REQ-006 opCodeA_i, opCodeB_i  in  7 each  0 nop, 10 immediate to register, 11 load, 12 store.
REQ-007 isWbA_i, isWbB_i  in  1 each; wbAddressA_i, wbAddressB_i  in  5 each; pOperandA_i, sOperandA_i, pOperandB_i, sOperandB_i  in  16 each  carried to the cache unchanged.
REQ-008 flush_i  in  1  stop granting and drain; flushDone_o  out  1  drain complete.
REQ-009 memValid_o  out  1; memOpCode_o  out  7; memIsWb_o  out  1; memWbAddress_o  out  5; memPOperand_o, memSOperand_o  out  16  registered single cache issue port.
REQ-010 memWbEnable_i  in  1; memWbAddress_i  in  5; memWbData_i  in  16  cache write-back return.
REQ-011 wbEnableA_o, wbEnableB_o  out  1; wbAddressA_o, wbAddressB_o  out  5; wbDataA_o, wbDataB_o  out  16  routed registered write-back per requester.

Function
REQ-012 The block SHALL grant at most one requester per cycle. When one valid is high and state is RUN, that requester SHALL be granted.
REQ-013 When both are valid, the block SHALL grant the requester that is not lastGrant. After every transfer, lastGrant SHALL update to the winner.
REQ-014 An accepted opcode 10, 11 or 12 SHALL appear on the mem* outputs with memValid_o=1 exactly 1 cycle after acceptance. memValid_o SHALL be 0 in every other cycle.
REQ-015 An accepted opcode 0 or any opcode outside {10,11,12} SHALL be consumed, SHALL update lastGrant, and SHALL NOT be issued (memValid_o=0).
REQ-016 An owner tag pipeline of MEM_LATENCY stages {valid, owner} SHALL shift every cycle and SHALL be loaded with {memValid_o, owner} at issue.
REQ-017 When the last tag stage is valid, memWbEnable_i/memWbAddress_i/memWbData_i SHALL be registered onto the owner's wb* outputs. The other requester's wbEnable SHALL be 0 in that cycle. Total request-to-writeback latency is MEM_LATENCY+2 cycles.
REQ-018 memWbEnable_i high while the last tag stage is invalid SHALL be ignored, and both wbEnable outputs SHALL stay 0.
REQ-019 An outstanding counter (width ceil(log2(MEM_LATENCY+1))+1) SHALL increment on issue, decrement on last-stage retire, and hold when both occur in the same cycle.
REQ-020 The FSM SHALL have three states:
 - RUN: grants allowed; flush_i=1 moves to DRAIN with no grant in that cycle.
 - DRAIN: no grants; when the counter is 0 and memValid_o is 0, move to DONE.
 - DONE: flushDone_o=1, no grants; flush_i=0 returns to RUN.
REQ-021 In DRAIN, flush_i deassertion SHALL NOT abort the drain.
REQ-022 A request held with valid and no ready SHALL NOT be lost. The block SHALL be insensitive to input changes while ready is low.

Reset
REQ-023 With reset_ni low, the block SHALL immediately (asynchronously) enter the following state:
 - FSM in RUN; lastGrant=B, so A wins the first tie.
 - Tag pipeline and counter cleared.
 - memValid_o, all wbEnable outputs and flushDone_o at 0.
 - All data, address and opcode outputs at 0.
REQ-024 Assertion of reset_ni while operations are in flight SHALL discard them. Returns arriving after release SHALL be ignored per REQ-018.
REQ-025 The first grant SHALL be possible in the first clock edge after reset_ni rises.

Configuration
REQ-026 With macro L1D_ARB_FIXED_PRIO_EN defined, requester A SHALL always win simultaneous requests and lastGrant SHALL be unused. Without the macro, REQ-013 round-robin applies.

Verification
REQ-027 Reset then A-only load (op 11, sOperand=0x0040, wbAddr=3, isWb=1), cache returns 0xBEEF -> memValid_o at cycle 1, wbEnableA_o=1 with wbAddressA_o=3 and wbDataA_o=0xBEEF at cycle 5, wbEnableB_o=0 throughout.
REQ-028 A and B both valid for 4 cycles with stores (op 12) -> grants A,B,A,B. Under L1D_ARB_FIXED_PRIO_EN -> grants A,A,A,A while B is stalled.
REQ-029 A issues op 10 (sOperand=0x1234, wbAddr=7) and B issues op 11 (wbAddr=9) back-to-back -> write-backs return in issue order to the correct ports with their addresses.
REQ-030 flush_i asserted with 3 operations outstanding -> no grants, flushDone_o rises only after the 3rd return. Deasserting flush_i then -> grant next cycle.
REQ-031 reset_ni pulsed low mid-stream with 2 loads outstanding -> outputs are 0 immediately, and later memWbEnable_i pulses produce no wbEnable.
REQ-032 Op 0 and op 5 from A -> reqReadyA_o=1, memValid_o stays 0, counter unchanged.
